// File: rtl/i2s_pcm_rx_if.sv
// I2S pin bundle plus PCM result side of the i2s_pcm_rx receiver.
// The slave modport is the receiver; master is whoever drives the pins.
interface i2s_pcm_rx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    enable_i;
  logic                    i2s_bclk_i;
  logic                    i2s_lrclk_i;
  logic                    i2s_sd_i;
  logic [SAMPLE_WIDTH-1:0] pcm_o;
  logic                    pcm_ready_o;
  logic                    frame_err_o;
  logic                    locked_o;

  modport master (
    output enable_i,
    output i2s_bclk_i,
    output i2s_lrclk_i,
    output i2s_sd_i,
    input  pcm_o,
    input  pcm_ready_o,
    input  frame_err_o,
    input  locked_o
  );

  modport slave (
    input  enable_i,
    input  i2s_bclk_i,
    input  i2s_lrclk_i,
    input  i2s_sd_i,
    output pcm_o,
    output pcm_ready_o,
    output frame_err_o,
    output locked_o
  );
endinterface

// File: rtl/i2s_pcm_rx.sv
// Philips I2S receiver: resynchronises BCLK/LRCLK/SD into clk and emits
// one PCM word per frame for the selected channel as a one-cycle strobe.
module i2s_pcm_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int CHANNEL_SEL  = 0
) (
  input logic          clk,
  input logic          rst,
  i2s_pcm_rx_if.slave  bus
);

  localparam int   CW  = $clog2(SLOT_WIDTH + 1);
  localparam logic SEL = (CHANNEL_SEL != 0);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [2:0] bclk_sync_q, bclk_sync_d;
  logic [1:0] lr_sync_q, lr_sync_d;
  logic [1:0] sd_sync_q, sd_sync_d;

  logic lr_q, lr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] pcm_q, pcm_d;
  logic ready_q, ready_d;
  logic err_q, err_d;

  logic rise;
  logic lr_s;
  logic sd_s;
  logic word_end;
  logic sel;
  logic take;
  logic full;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] pad;
  logic [SAMPLE_WIDTH-1:0] shift_in;

  assign lr_s     = lr_sync_q[1];
  assign sd_s     = sd_sync_q[1];
  assign rise     = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign word_end = lr_s ^ lr_q;
  assign sel      = (lr_q == SEL);
  assign take     = sel && (cnt_q < CW'(SAMPLE_WIDTH));

  // full: this LSB completes at least SAMPLE_WIDTH bits of the slot
  assign full     = (cnt_q >= CW'(SAMPLE_WIDTH - 1));
  assign pad      = CW'(SAMPLE_WIDTH - 1) - cnt_q;

  assign cnt_inc  = (cnt_q == CW'(SLOT_WIDTH)) ? cnt_q
                                               : cnt_q + 1'b1;

  assign shift_in = take ? {shift_q[SAMPLE_WIDTH-2:0], sd_s}
                         : shift_q;

  always_comb begin
    state_d     = state_q;
    bclk_sync_d = {bclk_sync_q[1:0], bus.i2s_bclk_i};
    lr_sync_d   = {lr_sync_q[0], bus.i2s_lrclk_i};
    sd_sync_d   = {sd_sync_q[0], bus.i2s_sd_i};
    lr_d        = lr_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pcm_d       = pcm_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;

    if (rise) begin
      if (word_end) begin
        lr_d = lr_s;
      end
      unique case (state_q)
        IDLE: begin
          if (word_end) begin
            state_d = RUN;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        RUN: begin
          if (word_end) begin
            cnt_d   = '0;
            shift_d = '0;
            if (sel) begin
              pcm_d   = full ? shift_in
                             : (shift_in << pad);
              ready_d = 1'b1;
              err_d   = ~full;
            end
          end else begin
            cnt_d   = cnt_inc;
            shift_d = shift_in;
          end
        end
      endcase
    end

    // LRCLK keeps being tracked while disabled so re-enable realigns
    if (!bus.enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      pcm_d   = pcm_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      lr_q        <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      pcm_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      lr_q        <= lr_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pcm_q       <= pcm_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.pcm_o       = pcm_q;
  assign bus.pcm_ready_o = ready_q;
  assign bus.frame_err_o = err_q;
  assign bus.locked_o    = (state_q == RUN);

endmodule

// File: tb/tb_i2s_pcm_rx.sv
// Directed bench for i2s_pcm_rx: left- and right-channel receivers fed
// from one generated I2S stream, strobes collected and checked per test.
module tb_i2s_pcm_rx;

  localparam int H = 4;

  typedef struct {
    logic [15:0] pcm;
    logic        err;
    int          cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   end_cyc [2];
  logic carry;
  ev_t  q0 [$];
  ev_t  q1 [$];

  i2s_pcm_rx_if #(.SAMPLE_WIDTH(16)) bus0 ();
  i2s_pcm_rx_if #(.SAMPLE_WIDTH(16)) bus1 ();

  assign bus1.enable_i    = bus0.enable_i;
  assign bus1.i2s_bclk_i  = bus0.i2s_bclk_i;
  assign bus1.i2s_lrclk_i = bus0.i2s_lrclk_i;
  assign bus1.i2s_sd_i    = bus0.i2s_sd_i;

  i2s_pcm_rx #(
    .SAMPLE_WIDTH(16),
    .SLOT_WIDTH(32),
    .CHANNEL_SEL(0)
  ) dut_l (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  i2s_pcm_rx #(
    .SAMPLE_WIDTH(16),
    .SLOT_WIDTH(32),
    .CHANNEL_SEL(1)
  ) dut_r (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.pcm_ready_o)
      q0.push_back('{bus0.pcm_o, bus0.frame_err_o, cyc});
    if (bus1.pcm_ready_o)
      q1.push_back('{bus1.pcm_o, bus1.frame_err_o, cyc});
  end

  // One slot of n BCLKs; SD lags LRCLK by one bit, so period 0
  // carries the LSB of the previous slot.
  task automatic send_slot(input logic ch, input logic [31:0] data,
                           input int n);
    for (int i = 0; i < n; i++) begin
      bus0.i2s_bclk_i  = 1'b0;
      bus0.i2s_lrclk_i = ch;
      bus0.i2s_sd_i    = (i == 0) ? carry : data[32-i];
      repeat (H) @(negedge clk);
      bus0.i2s_bclk_i = 1'b1;
      if (i == 0) end_cyc[!ch] = cyc;
      repeat (H) @(negedge clk);
    end
    carry = data[32-n];
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, {l, 16'h0}, 32);
    send_slot(1'b1, {r, 16'h0}, 32);
  endtask

  task automatic gap();
    bus0.enable_i = 1'b0;
    send_slot(1'b0, 32'h0, 4);
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus0.pcm_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_pcm got %h want 0000", bus0.pcm_o);
    end
    checks++;
    if (bus0.pcm_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", bus0.pcm_ready_o);
    end
    checks++;
    if (bus0.frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", bus0.frame_err_o);
    end
    checks++;
    if (bus0.locked_o !== 1'b0 || bus1.locked_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked got %b%b want 00",
               bus0.locked_o, bus1.locked_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    gap();
    bus0.enable_i = 1'b1;
    repeat (4) send_frame(16'h1234, 16'hABCD);
    checks++;
    if (q0.size() != 3) begin
      errors++;
      $display("FAIL nom_count got %0d want 3", q0.size());
    end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].pcm !== 16'h1234 || q0[i].err !== 1'b0) begin
        errors++;
        $display("FAIL nom_word%0d got %h/%b want 1234/0",
                 i, q0[i].pcm, q0[i].err);
      end
    end
    if (q0.size() > 0) begin
      checks++;
      if (q0[q0.size()-1].cyc != end_cyc[0] + 3) begin
        errors++;
        $display("FAIL nom_latency got %0d want %0d",
                 q0[q0.size()-1].cyc, end_cyc[0] + 3);
      end
    end
    checks++;
    if (bus0.locked_o !== 1'b1 || bus0.pcm_o !== 16'h1234) begin
      errors++;
      $display("FAIL nom_hold got %b/%h want 1/1234",
               bus0.locked_o, bus0.pcm_o);
    end
  endtask

  task automatic test_channel_sel();
    gap();
    bus0.enable_i = 1'b1;
    send_frame(16'h1111, 16'hABCD);
    send_frame(16'h2222, 16'h5A5A);
    send_frame(16'h3333, 16'h0F0F);
    checks++;
    if (q1.size() != 2) begin
      errors++;
      $display("FAIL sel_count got %0d want 2", q1.size());
    end else begin
      checks++;
      if (q1[0].pcm !== 16'hABCD || q1[1].pcm !== 16'h5A5A) begin
        errors++;
        $display("FAIL sel_words got %h %h want abcd 5a5a",
                 q1[0].pcm, q1[1].pcm);
      end
    end
  endtask

  task automatic test_enable_mid();
    gap();
    fork
      send_slot(1'b0, {16'h1111, 16'h0}, 32);
      begin
        repeat (80) @(negedge clk);
        bus0.enable_i = 1'b1;
      end
    join
    checks++;
    if (bus0.locked_o !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL en_prelock got %b/%0d want 0/0",
               bus0.locked_o, q0.size());
    end
    send_slot(1'b1, {16'h9999, 16'h0}, 32);
    checks++;
    if (bus0.locked_o !== 1'b1 || q0.size() != 0) begin
      errors++;
      $display("FAIL en_lock got %b/%0d want 1/0",
               bus0.locked_o, q0.size());
    end
    send_frame(16'h2222, 16'h8888);
    send_slot(1'b0, {16'h3333, 16'h0}, 32);
    checks++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL en_count got %0d want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].pcm !== 16'h2222) begin
        errors++;
        $display("FAIL en_first got %h want 2222", q0[0].pcm);
      end
    end
    checks++;
    if (q1.size() != 2) begin
      errors++;
      $display("FAIL en_rcount got %0d want 2", q1.size());
    end else begin
      checks++;
      if (q1[0].pcm !== 16'h9999 || q1[1].pcm !== 16'h8888) begin
        errors++;
        $display("FAIL en_right got %h %h want 9999 8888",
                 q1[0].pcm, q1[1].pcm);
      end
    end
  endtask

  task automatic test_short();
    gap();
    bus0.enable_i = 1'b1;
    repeat (3) begin
      send_slot(1'b0, {8'hA5, 24'h0}, 8);
      send_slot(1'b1, {8'h3C, 24'h0}, 8);
    end
    send_slot(1'b0, {8'hA5, 24'h0}, 8);
    checks++;
    if (q0.size() != 2) begin
      errors++;
      $display("FAIL short_count got %0d want 2", q0.size());
    end
    for (int i = 0; i < 2 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].pcm !== 16'hA500 || q0[i].err !== 1'b1) begin
        errors++;
        $display("FAIL short_left%0d got %h/%b want a500/1",
                 i, q0[i].pcm, q0[i].err);
      end
    end
    checks++;
    if (q1.size() != 3) begin
      errors++;
      $display("FAIL short_rcount got %0d want 3", q1.size());
    end else begin
      checks++;
      if (q1[0].pcm !== 16'h3C00 || q1[0].err !== 1'b1) begin
        errors++;
        $display("FAIL short_right got %h/%b want 3c00/1",
                 q1[0].pcm, q1[0].err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [12];
    vals = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000,
             16'h0000, 16'h5A82, 16'h7FFF, 16'h5A82,
             16'h0000, 16'hA57E, 16'h8001, 16'hA57E};
    gap();
    bus0.enable_i = 1'b1;
    for (int i = 0; i < 12; i++) send_frame(vals[i], ~vals[i]);
    checks++;
    if (q0.size() != 11) begin
      errors++;
      $display("FAIL b2b_count got %0d want 11", q0.size());
    end
    for (int i = 0; i < 11 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].pcm !== vals[i+1] || q0[i].err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_word%0d got %h/%b want %h/0",
                 i, q0[i].pcm, q0[i].err, vals[i+1]);
      end
      if (i > 0) begin
        checks++;
        if (q0[i].cyc - q0[i-1].cyc != 512) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want 512",
                   i, q0[i].cyc - q0[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    gap();
    bus0.enable_i = 1'b1;
    send_frame(16'h1111, 16'h2222);
    checks++;
    if (bus0.locked_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_prelock got %b want 1", bus0.locked_o);
    end
    fork
      send_slot(1'b0, {16'h5555, 16'h0}, 32);
      begin
        repeat (6 * 2 * H + 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus0.pcm_o !== 16'h0 || bus0.pcm_ready_o !== 1'b0 ||
            bus0.frame_err_o !== 1'b0 || bus0.locked_o !== 1'b0) begin
          errors++;
          $display("FAIL rmid_clear got %h/%b/%b/%b want 0000/0/0/0",
                   bus0.pcm_o, bus0.pcm_ready_o,
                   bus0.frame_err_o, bus0.locked_o);
        end
      end
    join
    checks++;
    if (bus0.locked_o !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL rmid_idle got %b/%0d want 0/0",
               bus0.locked_o, q0.size());
    end
    send_slot(1'b1, {16'h6666, 16'h0}, 32);
    checks++;
    if (bus0.locked_o !== 1'b1 || q0.size() != 0) begin
      errors++;
      $display("FAIL rmid_relock got %b/%0d want 1/0",
               bus0.locked_o, q0.size());
    end
    send_frame(16'h3333, 16'h4444);
    checks++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL rmid_count got %0d want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].pcm !== 16'h3333) begin
        errors++;
        $display("FAIL rmid_word got %h want 3333", q0[0].pcm);
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    carry            = 1'b0;
    end_cyc          = '{0, 0};
    rst              = 1'b1;
    bus0.enable_i    = 1'b0;
    bus0.i2s_bclk_i  = 1'b0;
    bus0.i2s_lrclk_i = 1'b0;
    bus0.i2s_sd_i    = 1'b0;
    test_reset();
    test_nominal();
    test_channel_sel();
    test_enable_mid();
    test_short();
    test_back_to_back();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
